// File: rtl/uart_debug_ctrl.sv
// rtl/uart_debug_ctrl.sv - UART command sequencer driving core run/step and streaming PC/debug words
module uart_debug_ctrl #(
  parameter int          NUM_WORDS = 32,
  parameter int          ADDR_BITS = 5,
  parameter logic [7:0]  ACK_BYTE  = 8'h4B,
  parameter logic [7:0]  NAK_BYTE  = 8'h3F
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_ready,
  output logic                 rd_uart,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_done_tick,
  input  logic [31:0]          pc_in,
  output logic [ADDR_BITS-1:0] dbg_addr,
  input  logic [31:0]          dbg_data,
  output logic                 cpu_run,
  output logic                 cpu_step,
  output logic                 busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] DECODE    = 3'd1;
  localparam logic [2:0] STEP_WAIT = 3'd2;
  localparam logic [2:0] RD_WAIT   = 3'd3;
  localparam logic [2:0] LOAD      = 3'd4;
  localparam logic [2:0] SEND      = 3'd5;
  localparam logic [2:0] WAIT_TX   = 3'd6;
  localparam logic [2:0] NEXT      = 3'd7;

  localparam logic [7:0] CMD_GO   = 8'h47;
  localparam logic [7:0] CMD_HALT = 8'h48;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_DUMP = 8'h44;

  // Index of the final word of a dump, in counter width.
  localparam logic [ADDR_BITS-1:0] LAST_WORD = ADDR_BITS'(NUM_WORDS - 1);

  logic [2:0]           state;
  logic [7:0]           cmd;
  logic [31:0]          shreg;
  logic [2:0]           byte_cnt;
  logic [ADDR_BITS-1:0] word_cnt;
  logic                 dumping;
  logic                 last_byte;
  logic                 more_words;

  // Helpers shared by the WAIT_TX and NEXT transitions.
  always_comb begin
    last_byte  = (byte_cnt == 3'd1);
    more_words = dumping && (word_cnt < LAST_WORD);
  end

  // Sequencer: command decode, reply loading and byte-by-byte transmit handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cmd      <= 8'h00;
      shreg    <= 32'h0;
      byte_cnt <= 3'd0;
      word_cnt <= '0;
      dumping  <= 1'b0;
      rd_uart  <= 1'b0;
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
      dbg_addr <= '0;
      cpu_run  <= 1'b0;
      cpu_step <= 1'b0;
      busy     <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      rd_uart  <= 1'b0;
      tx_start <= 1'b0;
      cpu_step <= 1'b0;

      case (state)
        IDLE: begin
          if (rx_ready) begin
            cmd     <= rx_data;
            rd_uart <= 1'b1;
            busy    <= 1'b1;
            state   <= DECODE;
          end
        end

        DECODE: begin
          dumping <= 1'b0;
          if (cmd == CMD_GO) begin
            cpu_run  <= 1'b1;
            shreg    <= {ACK_BYTE, 24'h0};
            byte_cnt <= 3'd1;
            state    <= SEND;
          end else if (cmd == CMD_HALT) begin
            cpu_run  <= 1'b0;
            shreg    <= {ACK_BYTE, 24'h0};
            byte_cnt <= 3'd1;
            state    <= SEND;
          end else if (cmd == CMD_STEP && !cpu_run) begin
            // A step is only meaningful on a halted core.
            cpu_step <= 1'b1;
            state    <= STEP_WAIT;
          end else if (cmd == CMD_DUMP) begin
            dumping  <= 1'b1;
            word_cnt <= '0;
            dbg_addr <= '0;
            state    <= RD_WAIT;
          end else begin
            shreg    <= {NAK_BYTE, 24'h0};
            byte_cnt <= 3'd1;
            state    <= SEND;
          end
        end

        STEP_WAIT: begin
          // The step pulse has been seen by the core; pc_in now reflects it.
          shreg    <= pc_in;
          byte_cnt <= 3'd4;
          state    <= SEND;
        end

        RD_WAIT: begin
          // dbg_data lags dbg_addr by one cycle.
          state <= LOAD;
        end

        LOAD: begin
          shreg    <= dbg_data;
          byte_cnt <= 3'd4;
          state    <= SEND;
        end

        SEND: begin
          tx_data  <= shreg[31:24];
          tx_start <= 1'b1;
          state    <= WAIT_TX;
        end

        WAIT_TX: begin
          if (tx_done_tick) begin
            shreg    <= {shreg[23:0], 8'h00};
            byte_cnt <= byte_cnt - 3'd1;
            state    <= last_byte ? NEXT : SEND;
          end
        end

        NEXT: begin
          if (more_words) begin
            word_cnt <= word_cnt + 1'b1;
            dbg_addr <= word_cnt + 1'b1;
            state    <= RD_WAIT;
          end else begin
            dumping <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_debug_ctrl.sv
// tb/tb_uart_debug_ctrl.sv - scoreboard bench for uart_debug_ctrl
module tb_uart_debug_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        rd_uart;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done_tick;
  logic [31:0] pc_in;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        cpu_run;
  logic        cpu_step;
  logic        busy;

  uart_debug_ctrl #(
    .NUM_WORDS(32),
    .ADDR_BITS(5),
    .ACK_BYTE (8'h4B),
    .NAK_BYTE (8'h3F)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .rd_uart     (rd_uart),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_done_tick(tx_done_tick),
    .pc_in       (pc_in),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .cpu_run     (cpu_run),
    .cpu_step    (cpu_step),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Debug bank: one-cycle read latency, word k holds k.
  always @(posedge clk) dbg_data <= {27'h0, dbg_addr};

  int         checks;
  int         errors;
  logic [7:0] exp_q[$];
  int         tx_count;
  int         rd_count;
  int         step_count;
  int         tx_lat;
  logic       inflight;
  int         lat_cnt;
  logic [7:0] cur_byte;
  logic       prev_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic push_dump();
    for (int k = 0; k < 32; k++) push_word(k);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    logic done;
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && !rx_ready && !inflight && !tx_done_tick) done = 1'b1;
    end
    check(tag, done, 1'b1);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int r0;
    int s0;
    int t0;
    logic got;
    checks = 0; errors = 0;
    tx_count = 0; rd_count = 0; step_count = 0;
    tx_lat = 2; inflight = 1'b0; lat_cnt = 0; cur_byte = 8'h00; prev_rd = 1'b0;
    rst = 1'b1; rx_data = 8'h00; rx_ready = 1'b0; tx_done_tick = 1'b0;
    pc_in = 32'h0;

    // RX buffer, TX model and output monitor, all on the falling edge.
    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          inflight     = 1'b0;
          tx_done_tick = 1'b0;
          exp_q.delete();
          prev_rd      = 1'b0;
        end else begin
          if (tx_done_tick) tx_done_tick = 1'b0;
          else if (inflight) begin
            check("tx_data_stable", tx_data, cur_byte);
            if (lat_cnt == 0) begin
              tx_done_tick = 1'b1;
              inflight     = 1'b0;
            end else lat_cnt--;
          end
          if (tx_start) begin
            check("tx_overlap", inflight, 1'b0);
            check("tx_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("tx_byte", tx_data, exp_q.pop_front());
            inflight = 1'b1;
            lat_cnt  = tx_lat;
            cur_byte = tx_data;
            tx_count++;
          end
          if (rd_uart) begin
            check("rd_uart_width", prev_rd, 1'b0);
            rx_ready = 1'b0;
            rd_count++;
          end
          prev_rd = rd_uart;
          if (cpu_step) begin
            check("step_while_run", cpu_run, 1'b0);
            step_count++;
          end
        end
      end
    join_none

    wait_cycles(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rd_uart", rd_uart, 1'b0);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_cpu_run", cpu_run, 1'b0);
    check("rst_cpu_step", cpu_step, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_dbg_addr", dbg_addr, 5'd0);

    // 'G': ack, core runs two cycles after capture.
    exp_q.push_back(8'h4B);
    send_cmd(8'h47);
    @(negedge clk);
    check("g_rd_uart_hi", rd_uart, 1'b1);
    check("g_busy", busy, 1'b1);
    check("g_run_not_yet", cpu_run, 1'b0);
    @(negedge clk);
    check("g_rd_uart_lo", rd_uart, 1'b0);
    check("g_cpu_run", cpu_run, 1'b1);
    wait_idle("g_idle", 100);
    check("g_run_kept", cpu_run, 1'b1);

    // 'H': halt.
    exp_q.push_back(8'h4B);
    send_cmd(8'h48);
    wait_idle("h_idle", 100);
    check("h_cpu_run", cpu_run, 1'b0);

    // 'S' on a halted core: one step, PC MSB first.
    tx_lat = 3;
    pc_in = 32'h0040_0010;
    s0 = step_count;
    push_word(32'h0040_0010);
    send_cmd(8'h53);
    wait_idle("s_idle", 200);
    check("s_step_pulses", step_count - s0, 1);

    // 'D': full dump at minimum transmitter latency.
    tx_lat = 0;
    t0 = tx_count;
    push_dump();
    send_cmd(8'h44);
    wait_idle("d_idle", 3000);
    check("d_byte_count", tx_count - t0, 128);
    check("d_dbg_addr_end", dbg_addr, 5'd31);
    check("d_busy", busy, 1'b0);

    // Unknown byte, then 'S' while running is also rejected.
    tx_lat = 1;
    exp_q.push_back(8'h3F);
    send_cmd(8'h7A);
    wait_idle("nak_idle", 100);
    exp_q.push_back(8'h4B);
    send_cmd(8'h47);
    wait_idle("g2_idle", 100);
    s0 = step_count;
    exp_q.push_back(8'h3F);
    send_cmd(8'h53);
    wait_idle("s_run_idle", 100);
    check("s_run_no_step", step_count - s0, 0);
    check("s_run_kept", cpu_run, 1'b1);

    // Command arriving mid-dump waits in the RX buffer.
    tx_lat = 2;
    push_dump();
    send_cmd(8'h44);
    wait_cycles(40);
    r0 = rd_count;
    exp_q.push_back(8'h4B);
    send_cmd(8'h48);
    wait_cycles(100);
    check("mid_no_rd", rd_count, r0);
    check("mid_busy", busy, 1'b1);
    wait_idle("mid_idle", 5000);
    check("mid_rd_after", rd_count - r0, 1);
    check("mid_halted", cpu_run, 1'b0);

    // Stray tx_done_tick in IDLE.
    t0 = tx_count;
    tx_done_tick = 1'b1;
    wait_cycles(5);
    check("stray_busy", busy, 1'b0);
    check("stray_no_tx", tx_count, t0);
    check("stray_tx_data", tx_data, 8'h4B);

    // Reset while waiting on byte 2 of a dump, with the core running.
    exp_q.push_back(8'h4B);
    send_cmd(8'h47);
    wait_idle("g3_idle", 100);
    tx_lat = 6;
    t0 = tx_count;
    push_dump();
    send_cmd(8'h44);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (tx_count == t0 + 2) got = 1'b1;
    end
    check("rst_reach_byte2", got, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_rd_uart", rd_uart, 1'b0);
    check("mrst_tx_start", tx_start, 1'b0);
    check("mrst_cpu_run", cpu_run, 1'b0);
    check("mrst_cpu_step", cpu_step, 1'b0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_tx_data", tx_data, 8'h00);
    check("mrst_dbg_addr", dbg_addr, 5'd0);
    t0 = tx_count;
    rst = 1'b0;
    wait_cycles(40);
    check("mrst_no_tx", tx_count, t0);
    check("mrst_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
